rtc_transaction_scheduler: RTL and testbench

- Sits directly upstream of the RTC write sequencer and its sibling read sequencer.
- Arbitrates user write requests against periodic time refresh reads.
- Holds the sequencer enables `do_it_esc` / `do_it_lee` high for exactly one full bus transaction, then guarantees a low gap so the downstream counter returns to its idle state and restarts from 0.
- Reports completion pulses to the display/edit logic.

---
 rtl/rtc_pkg.sv | 33 +++
 rtl/rtc_refresh_timer.sv | 43 ++++
 rtl/rtc_transaction_scheduler.sv | 158 +++++++++++++++
 tb/tb_rtc_transaction_scheduler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC transaction scheduler and the RTC read/write
// sequencers: state encodings, default burst lengths and burst counter width.
package rtc_pkg;

  // Burst counter width shared with the write/read sequencers (holds 0..511).
  localparam int BURST_CNT_W = 9;

  // One complete burst covers all 10 address/data pairs.
  localparam int WR_CYCLES_DEF = 432;
  localparam int RD_CYCLES_DEF = 432;

  // State encodings chosen so the enables decode from state bits alone:
  // bit0 set only in ESC, bit1 without bit2 only in LEE, any bit means busy.
  localparam logic [2:0] ST_IDLE_ENC    = 3'b000;
  localparam logic [2:0] ST_ESC_ENC     = 3'b001;
  localparam logic [2:0] ST_LEE_ENC     = 3'b010;
  localparam logic [2:0] ST_GAP_ESC_ENC = 3'b100;
  localparam logic [2:0] ST_GAP_LEE_ENC = 3'b110;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE_ENC,
    ESC     = ST_ESC_ENC,
    LEE     = ST_LEE_ENC,
    GAP_ESC = ST_GAP_ESC_ENC,
    GAP_LEE = ST_GAP_LEE_ENC
  } state_e;

  // Terminal count of a phase that lasts 'cycles' clocks, counted from 0.
  function automatic logic [BURST_CNT_W-1:0] lastCount(input int cycles);
    return BURST_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/rtc_refresh_timer.sv
// Periodic refresh timer: counts while enabled, raises a single-cycle tick on
// the terminal count and wraps to 0. Disabling it holds the count at 0.
module rtc_refresh_timer
  import rtc_pkg::*;
#(
  parameter int REFRESH_CYCLES = 10_000_000,
  parameter int TMR_W          = 24
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH_CYCLES - 1);

  logic [TMR_W-1:0] count_q;
  logic [TMR_W-1:0] count_d;

  // Next count and terminal-count tick.
  always_comb begin
    count_d = count_q;
    tick_o  = 1'b0;
    if (!en_i) begin
      count_d = '0;
    end else if (count_q == TMR_LAST) begin
      count_d = '0;
      tick_o  = 1'b1;
    end else begin
      count_d = count_q + TMR_W'(1);
    end
  end

  // Timer register, cleared asynchronously.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rtc_transaction_scheduler.sv
// RTC transaction scheduler: arbitrates user writes against periodic and
// immediate reads, holds one sequencer enable for exactly one burst and then
// forces a low gap so the downstream sequencer counter restarts from 0.
// Optional feature macro RTC_BOOT_WRITE_EN: when defined, esc_pending comes
// out of reset set, so the first transaction initialises the RTC registers.
module rtc_transaction_scheduler
  import rtc_pkg::*;
#(
  parameter int WR_CYCLES      = WR_CYCLES_DEF,
  parameter int RD_CYCLES      = RD_CYCLES_DEF,
  parameter int GAP_CYCLES     = 4,
  parameter int REFRESH_CYCLES = 10_000_000,
  parameter int TMR_W          = 24
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic req_esc_i,
  input  logic req_lee_i,
  input  logic refresh_en_i,
  output logic do_it_esc_o,
  output logic do_it_lee_o,
  output logic busy_o,
  output logic esc_pending_o,
  output logic esc_done_o,
  output logic lee_done_o
);

  localparam logic [BURST_CNT_W-1:0] WR_LAST  = lastCount(WR_CYCLES);
  localparam logic [BURST_CNT_W-1:0] RD_LAST  = lastCount(RD_CYCLES);
  localparam logic [BURST_CNT_W-1:0] GAP_LAST = lastCount(GAP_CYCLES);

`ifdef RTC_BOOT_WRITE_EN
  localparam logic ESC_PENDING_RST = 1'b1;
`else
  localparam logic ESC_PENDING_RST = 1'b0;
`endif

  state_e                 state_q;
  state_e                 state_d;
  logic [2:0]             stateBits;
  logic [BURST_CNT_W-1:0] burstCnt_q;
  logic [BURST_CNT_W-1:0] burstCnt_d;
  logic                   escPending_q;
  logic                   escPending_d;
  logic                   leePending_q;
  logic                   leePending_d;
  logic                   escDone_q;
  logic                   escDone_d;
  logic                   leeDone_q;
  logic                   leeDone_d;
  logic                   escTake;
  logic                   leeTake;
  logic                   refreshTick;

  rtc_refresh_timer #(
    .REFRESH_CYCLES (REFRESH_CYCLES),
    .TMR_W          (TMR_W)
  ) u_refresh_timer (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .en_i     (refresh_en_i),
    .tick_o   (refreshTick)
  );

  // Next-state, burst/gap counting and done-pulse decisions.
  always_comb begin
    state_d    = state_q;
    burstCnt_d = burstCnt_q;
    escDone_d  = 1'b0;
    leeDone_d  = 1'b0;
    escTake    = 1'b0;
    leeTake    = 1'b0;
    case (state_q)
      IDLE: begin
        burstCnt_d = '0;
        if (escPending_q) begin
          state_d = ESC;
          escTake = 1'b1;
        end else if (leePending_q) begin
          state_d = LEE;
          leeTake = 1'b1;
        end
      end
      ESC: begin
        if (burstCnt_q == WR_LAST) begin
          state_d    = GAP_ESC;
          burstCnt_d = '0;
          escDone_d  = 1'b1;
        end else begin
          burstCnt_d = burstCnt_q + BURST_CNT_W'(1);
        end
      end
      GAP_ESC: begin
        if (burstCnt_q == GAP_LAST) begin
          state_d    = IDLE;
          burstCnt_d = '0;
        end else begin
          burstCnt_d = burstCnt_q + BURST_CNT_W'(1);
        end
      end
      LEE: begin
        if (burstCnt_q == RD_LAST) begin
          state_d    = GAP_LEE;
          burstCnt_d = '0;
          leeDone_d  = 1'b1;
        end else begin
          burstCnt_d = burstCnt_q + BURST_CNT_W'(1);
        end
      end
      GAP_LEE: begin
        if (burstCnt_q == GAP_LAST) begin
          state_d    = IDLE;
          burstCnt_d = '0;
        end else begin
          burstCnt_d = burstCnt_q + BURST_CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        burstCnt_d = '0;
      end
    endcase
  end

  // Pending flags: a new request in the same cycle as the grant keeps the flag set.
  always_comb begin
    escPending_d = req_esc_i | (escPending_q & ~escTake);
    leePending_d = req_lee_i | refreshTick | (leePending_q & ~leeTake);
  end

  // State, counter, pending and done registers; reset drops everything at once.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      burstCnt_q   <= '0;
      escPending_q <= ESC_PENDING_RST;
      leePending_q <= 1'b0;
      escDone_q    <= 1'b0;
      leeDone_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      burstCnt_q   <= burstCnt_d;
      escPending_q <= escPending_d;
      leePending_q <= leePending_d;
      escDone_q    <= escDone_d;
      leeDone_q    <= leeDone_d;
    end
  end

  assign stateBits     = state_q;
  assign do_it_esc_o   = stateBits[0];
  assign do_it_lee_o   = stateBits[1] & ~stateBits[2];
  assign busy_o        = |stateBits;
  assign esc_pending_o = escPending_q;
  assign esc_done_o    = escDone_q;
  assign lee_done_o    = leeDone_q;

endmodule

// File: tb/tb_rtc_transaction_scheduler.sv
// Directed testbench for rtc_transaction_scheduler with a short refresh period.
module tb_rtc_transaction_scheduler;

  localparam int WR  = 432;
  localparam int RD  = 432;
  localparam int GAP = 4;
  localparam int REF = 100;

  logic clk        = 1'b0;
  logic resetN     = 1'b0;
  logic reqEsc     = 1'b0;
  logic reqLee     = 1'b0;
  logic refreshEn  = 1'b0;
  logic doItEsc;
  logic doItLee;
  logic busy;
  logic escPending;
  logic escDone;
  logic leeDone;

  int cyc = 0;
  int errorCount = 0;
  int checkCount = 0;

  int escRise = 0, escFall = 0, leeRise = 0, leeFall = 0;
  int escBursts = 0, leeBursts = 0;
  int escDoneCnt = 0, leeDoneCnt = 0, escDoneAt = 0, leeDoneAt = 0;
  int busyFallAt = 0, overlapCnt = 0;
  logic prevEsc = 1'b0, prevLee = 1'b0, prevBusy = 1'b0;

  rtc_transaction_scheduler #(
    .WR_CYCLES      (WR),
    .RD_CYCLES      (RD),
    .GAP_CYCLES     (GAP),
    .REFRESH_CYCLES (REF),
    .TMR_W          (24)
  ) dut (
    .clk_i         (clk),
    .reset_ni      (resetN),
    .req_esc_i     (reqEsc),
    .req_lee_i     (reqLee),
    .refresh_en_i  (refreshEn),
    .do_it_esc_o   (doItEsc),
    .do_it_lee_o   (doItLee),
    .busy_o        (busy),
    .esc_pending_o (escPending),
    .esc_done_o    (escDone),
    .lee_done_o    (leeDone)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge k the value is k.
  always @(posedge clk) cyc <= cyc + 1;

  // Record enable edges, done pulses and overlap, sampled mid-cycle.
  always @(negedge clk) begin
    prevEsc  <= doItEsc;
    prevLee  <= doItLee;
    prevBusy <= busy;
    if (doItEsc && !prevEsc) begin escRise <= cyc; escBursts <= escBursts + 1; end
    if (!doItEsc && prevEsc) escFall <= cyc;
    if (doItLee && !prevLee) begin leeRise <= cyc; leeBursts <= leeBursts + 1; end
    if (!doItLee && prevLee) leeFall <= cyc;
    if (escDone) begin escDoneCnt <= escDoneCnt + 1; escDoneAt <= cyc; end
    if (leeDone) begin leeDoneCnt <= leeDoneCnt + 1; leeDoneAt <= cyc; end
    if (!busy && prevBusy) busyFallAt <= cyc;
    if (doItEsc && doItLee) overlapCnt <= overlapCnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one request cycle; returns the clock edge that samples it.
  task automatic applyStimulus(input logic esc, input logic lee, output int sampledEdge);
    @(negedge clk);
    reqEsc = esc;
    reqLee = lee;
    sampledEdge = cyc + 1;
    @(negedge clk);
    reqEsc = 1'b0;
    reqLee = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_timeout", busy, 0);
  endtask

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n, m, e, escBase, leeBase, doneBase, leeDoneBase;

    repeat (3) @(negedge clk);
`ifdef RTC_BOOT_WRITE_EN
    checkOutput("rst_outputs", {doItEsc, doItLee, busy, escPending, escDone, leeDone}, 6'b000100);
`else
    checkOutput("rst_outputs", {doItEsc, doItLee, busy, escPending, escDone, leeDone}, 6'b000000);
`endif
    resetN = 1'b1;
    @(negedge clk);
`ifdef RTC_BOOT_WRITE_EN
    checkOutput("boot_write_start", doItEsc, 1);
    waitIdle(1000);
`else
    waitCycles(20);
    checkOutput("post_rst_idle", {doItEsc, doItLee, busy, escPending}, 0);
`endif

    // Single write burst.
    doneBase = escDoneCnt;
    applyStimulus(1'b1, 1'b0, n);
    checkOutput("pend_set", escPending, 1);
    checkOutput("not_yet_busy", busy, 0);
    @(negedge clk);
    checkOutput("esc_rise_now", doItEsc, 1);
    waitIdle(1000);
    waitCycles(2);
    checkOutput("esc_rise_edge", escRise, n + 1);
    checkOutput("esc_len", escFall - escRise, WR);
    checkOutput("esc_done_edge", escDoneAt, n + WR + 1);
    checkOutput("esc_done_cnt", escDoneCnt - doneBase, 1);
    checkOutput("busy_fall_edge", busyFallAt, n + WR + GAP + 1);

    // Reset in cycle 200 of a write burst.
    applyStimulus(1'b1, 1'b0, n);
    waitUntil(n + 200);
    checkOutput("mid_burst_high", doItEsc, 1);
    doneBase = escDoneCnt;
    #2 resetN = 1'b0;
    #1 checkOutput("rst_async_drop", {doItEsc, busy, escDone}, 0);
    waitCycles(3);
    resetN = 1'b1;
    waitCycles(3);
    checkOutput("rst_no_done", escDoneCnt - doneBase, 0);
`ifdef RTC_BOOT_WRITE_EN
    waitIdle(1000);
`else
    waitCycles(20);
    checkOutput("rst_release_idle", {doItEsc, doItLee, busy, escPending}, 0);
`endif

    // Write request and refresh tick on the same edge, then refresh reads.
    escBase = escBursts;
    leeBase = leeBursts;
    leeDoneBase = leeDoneCnt;
    @(negedge clk);
    refreshEn = 1'b1;
    e = cyc + 1;
    waitUntil(e + 97);
    applyStimulus(1'b1, 1'b0, n);
    @(negedge clk);
    checkOutput("prio_esc_first", {doItEsc, doItLee}, 2'b10);
    waitUntil(n + WR + GAP + 1);
    checkOutput("prio_gap_idle", {doItEsc, doItLee, busy}, 0);
    @(negedge clk);
    checkOutput("prio_lee_start", doItLee, 1);
    waitUntil(n + 2 * (WR + GAP + 1) + 1);
    checkOutput("refresh_second", doItLee, 1);
    refreshEn = 1'b0;
    checkOutput("prio_esc_fall", escFall, n + WR + 1);
    checkOutput("lee1_fall", leeFall, n + WR + GAP + 2 + RD);
    waitIdle(1000);
    waitCycles(500);
    checkOutput("lee2_rise", leeRise, n + 2 * (WR + GAP + 1) + 1);
    checkOutput("lee2_len", leeFall - leeRise, RD);
    checkOutput("lee2_done_edge", leeDoneAt, n + 2 * (WR + GAP + 1) + 1 + RD);
    checkOutput("lee_bursts", leeBursts - leeBase, 2);
    checkOutput("lee_done_cnt", leeDoneCnt - leeDoneBase, 2);
    checkOutput("esc_bursts_prio", escBursts - escBase, 1);
    checkOutput("refresh_off_idle", busy, 0);

    // Three requests during a write coalesce into one more write.
    escBase = escBursts;
    doneBase = escDoneCnt;
    applyStimulus(1'b1, 1'b0, n);
    waitUntil(n + 50);
    applyStimulus(1'b1, 1'b0, m);
    checkOutput("coal_pend_set", escPending, 1);
    waitUntil(n + 100);
    applyStimulus(1'b1, 1'b0, m);
    waitUntil(n + 300);
    applyStimulus(1'b1, 1'b0, m);
    waitUntil(n + WR + GAP);
    checkOutput("coal_pend_gap", {escPending, doItEsc}, 2'b10);
    waitUntil(n + WR + GAP + 1);
    checkOutput("coal_pend_idle", {escPending, busy}, 2'b10);
    @(negedge clk);
    checkOutput("coal_second_start", {escPending, doItEsc}, 2'b01);
    waitIdle(1000);
    waitCycles(50);
    checkOutput("coal_bursts", escBursts - escBase, 2);
    checkOutput("coal_done_cnt", escDoneCnt - doneBase, 2);

    // Immediate read request.
    applyStimulus(1'b0, 1'b1, n);
    waitCycles(2);
    checkOutput("imm_lee_only", {doItEsc, doItLee}, 2'b01);
    waitIdle(1000);
    waitCycles(2);
    checkOutput("imm_lee_rise", leeRise, n + 1);
    checkOutput("imm_lee_done", leeDoneAt, n + RD + 1);
    checkOutput("no_overlap", overlapCnt, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
